// File: rtl/gpio_btn_debounce_if.sv
// Button pad / conditioned-event bundle for gpio_btn_debounce.
// slave: debouncer side (raw in, events out); master: consumer side.
interface gpio_btn_debounce_if #(
    parameter int N_BTN = 3
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_long;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long
    );
endinterface

// File: rtl/gpio_btn_debounce.sv
// Push-button conditioner: per channel 2-flop sync, debounce, polarity
// normalise; emits level plus 1-cycle press/release/long-press pulses.
// Ports: clk, rst_n (async active-low), btn (slave: btn_raw in; level,
// press, release, long out, all N_BTN wide and registered).
module gpio_btn_debounce #(
    parameter int N_BTN           = 3,
    parameter int ACTIVE_LOW      = 1,
    parameter int CNT_W           = 20,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_W          = 26,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic               clk,
    input  logic               rst_n,
    gpio_btn_debounce_if.slave btn
);
    localparam logic [N_BTN-1:0] REL =
        {N_BTN{ACTIVE_LOW != 0}};
    localparam logic [CNT_W-1:0] DB_TERM =
        CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LONG_W-1:0] LG_TERM =
        LONG_W'(LONG_CYCLES - 1);

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] sync_n;
    logic [N_BTN-1:0] stable;
    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] rel_q;
    logic [N_BTN-1:0] long_q;

    // Synchroniser resets to the released pin level so that
    // reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= REL;
            sync2 <= REL;
        end else begin
            sync1 <= btn.btn_raw;
            sync2 <= sync1;
        end
    end

    assign sync_n = sync2 ^ REL;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        logic [CNT_W-1:0]  cnt;
        logic [LONG_W-1:0] hold;
        logic              st;
        logic              pq;
        logic              rq;
        logic              lq;
        logic              fired;
        logic              done;

        // Debounce count completes this cycle: S is about to flip.
        assign done = (sync_n[g] != st) && (cnt == DB_TERM);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
                st  <= 1'b0;
                pq  <= 1'b0;
                rq  <= 1'b0;
            end else begin
                pq <= 1'b0;
                rq <= 1'b0;
                if (sync_n[g] == st) begin
                    cnt <= '0;
                end else if (cnt == DB_TERM) begin
                    cnt <= '0;
                    st  <= sync_n[g];
                    pq  <= sync_n[g];
                    rq  <= ~sync_n[g];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        // A flip in either direction clears the hold counter; a
        // release on the long-fire cycle suppresses the long pulse.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold  <= '0;
                fired <= 1'b0;
                lq    <= 1'b0;
            end else begin
                lq <= 1'b0;
                if (done) begin
                    hold  <= '0;
                    fired <= 1'b0;
                end else if (st && !fired) begin
                    if (hold == LG_TERM) begin
                        lq    <= 1'b1;
                        fired <= 1'b1;
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
            end
        end

        assign stable[g]  = st;
        assign press_q[g] = pq;
        assign rel_q[g]   = rq;
        assign long_q[g]  = lq;
    end

    assign btn.btn_level   = stable;
    assign btn.btn_press   = press_q;
    assign btn.btn_release = rel_q;
    assign btn.btn_long    = long_q;
endmodule

// File: tb/tb_gpio_btn_debounce.sv
// Self-checking bench for gpio_btn_debounce: window-based reference
// model checked every cycle, plus directed literal checks.
module tb_gpio_btn_debounce;
    localparam int N  = 3;
    localparam int AL = 1;
    localparam int DB = 4;
    localparam int LG = 10;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    gpio_btn_debounce_if #(.N_BTN(N)) bus ();

    gpio_btn_debounce #(
        .N_BTN(N),
        .ACTIVE_LOW(AL),
        .CNT_W(4),
        .DEBOUNCE_CYCLES(DB),
        .LONG_W(5),
        .LONG_CYCLES(LG)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: S flips when the D most recent synchronised
    // samples (raw delayed two edges) all disagree with S. Long
    // press fires exactly LG edges after the press edge.
    logic [N-1:0] hist [DB+1];
    logic [N-1:0] e_lvl, e_prs, e_rel, e_lng, m_fired;
    int cyc;
    int press_cyc [N];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j <= DB; j++) hist[j] <= '0;
            e_lvl   <= '0;
            e_prs   <= '0;
            e_rel   <= '0;
            e_lng   <= '0;
            m_fired <= '0;
        end else begin : mdl
            logic [N-1:0] nl, np, nr, ng, nf, pin;
            bit diff;
            nl = e_lvl;
            np = '0;
            nr = '0;
            ng = '0;
            nf = m_fired;
            for (int i = 0; i < N; i++) begin
                diff = 1'b1;
                for (int j = 1; j <= DB; j++)
                    if (hist[j][i] == e_lvl[i]) diff = 1'b0;
                if (diff) begin
                    nl[i] = ~e_lvl[i];
                    if (nl[i]) begin
                        np[i] = 1'b1;
                        press_cyc[i] <= cyc;
                    end else begin
                        nr[i] = 1'b1;
                        nf[i] = 1'b0;
                    end
                end else if (e_lvl[i] && !m_fired[i] &&
                             cyc - press_cyc[i] == LG) begin
                    ng[i] = 1'b1;
                    nf[i] = 1'b1;
                end
            end
            pin = (AL != 0) ? ~bus.btn_raw : bus.btn_raw;
            hist[0] <= pin;
            for (int j = 1; j <= DB; j++) hist[j] <= hist[j-1];
            e_lvl   <= nl;
            e_prs   <= np;
            e_rel   <= nr;
            e_lng   <= ng;
            m_fired <= nf;
            cyc     <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        chk("model",
            {20'd0, bus.btn_level, bus.btn_press,
             bus.btn_release, bus.btn_long},
            {20'd0, e_lvl, e_prs, e_rel, e_lng});
    end

    function automatic logic [31:0] outs();
        return {20'd0, bus.btn_level, bus.btn_press,
                bus.btn_release, bus.btn_long};
    endfunction

    initial begin
        int n;
        int cnt_a;
        int cnt_b;
        bit found;
        logic [6:0] pat;
        checks = 0;
        errors = 0;
        cyc = 0;
        bus.btn_raw = 3'b111;
        rst_n = 1'b0;
        #1;
        chk("reset_outs", outs(), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1 chk("idle_outs", outs(), 32'd0);
        end

        // Clean press on channel 0
        @(negedge clk) bus.btn_raw[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("press0_edge5", {30'd0, bus.btn_level[0],
                                bus.btn_press[0]}, 32'd0);
        @(posedge clk);
        #1 chk("press0_edge6", {30'd0, bus.btn_level[0],
                                bus.btn_press[0]}, 32'd3);
        @(posedge clk);
        #1 chk("press0_edge7", {31'd0, bus.btn_press[0]}, 32'd0);

        // Async reset while channel 0 is held
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_clear", outs(), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("rst_press_e5", {31'd0, bus.btn_press[0]}, 32'd0);
        @(posedge clk);
        #1 chk("rst_press_e6", {30'd0, bus.btn_level[0],
                                bus.btn_press[0]}, 32'd3);
        @(negedge clk) bus.btn_raw[0] = 1'b1;
        repeat (10) @(posedge clk);

        // Bounce on channel 1: 3 low, 1 high, 3 low, then high
        pat = 7'b000_1_000;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk) bus.btn_raw[1] = (k < 7) ? pat[k] : 1'b1;
            @(posedge clk);
            #1 chk("bounce1", {30'd0, bus.btn_level[1],
                               bus.btn_press[1]}, 32'd0);
        end

        // Long press on channel 2
        @(negedge clk) bus.btn_raw[2] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            #1 if (bus.btn_press[2]) found = 1'b1;
        end
        chk("press2_seen", {31'd0, found}, 32'd1);
        n = 0;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(posedge clk);
            #1 n++;
            if (bus.btn_long[2]) found = 1'b1;
        end
        chk("long2_delay", n, 32'd10);
        cnt_a = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1 if (bus.btn_long[2]) cnt_a++;
        end
        chk("long2_once", cnt_a, 32'd0);
        @(negedge clk) bus.btn_raw[2] = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1 if (bus.btn_release[2]) cnt_a++;
            if (bus.btn_long[2]) cnt_b++;
        end
        chk("rel2_count", cnt_a, 32'd1);
        chk("rel2_nolong", cnt_b, 32'd0);

        // Simultaneous press of all channels
        @(negedge clk) bus.btn_raw = 3'b000;
        repeat (5) @(posedge clk);
        #1 chk("simul_e5", {29'd0, bus.btn_press}, 32'd0);
        @(posedge clk);
        #1 chk("simul_e6", {29'd0, bus.btn_press}, 32'd7);
        @(posedge clk);
        #1 chk("simul_e7", {29'd0, bus.btn_press}, 32'd0);
        @(negedge clk) bus.btn_raw = 3'b111;
        repeat (20) @(posedge clk);

        // Randomised stimulus with bursts of bouncing and resets
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (((k / 200) % 3) == 2) begin
                    if ($urandom_range(0, 2) == 0)
                        bus.btn_raw[i] = ~bus.btn_raw[i];
                end else if ($urandom_range(0, 15) == 0) begin
                    bus.btn_raw[i] = ~bus.btn_raw[i];
                end
            end
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                @(posedge clk);
                @(posedge clk);
                #2 rst_n = 1'b1;
            end
        end

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
